// File: rtl/peripheral_timer.sv
`timescale 1ns/1ps
// peripheral_timer
//   Memory-mapped peripheral at 0x40000000 on the CPU data bus. It holds a
//   reloadable 32-bit interval timer that drives the processor interrupt
//   request, LED / seven-segment / switch I/O registers and a free-running
//   cycle counter.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous reset, active low
//   rd      in   load strobe (MemRead)
//   wr      in   store strobe (MemWrite)
//   addr    in   [31:0] byte address
//   wdata   in   [31:0] store data
//   rdata   out  [31:0] load data, combinational
//   led     out  [7:0]  LED register
//   switch  in   [7:0]  raw board switches (asynchronous)
//   digi    out  [11:0] seven-segment register {digit select, segments}
//   irqout  out  interrupt request (TCON[1] & TCON[2])

module peripheral_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi,
    output logic        irqout
);

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [7:0]  led_reg;
    logic [11:0] digi_reg;
    logic [31:0] systick;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;

    logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
    logic overflow;
    logic irq_set;

    // Full 32-bit compare: misaligned or out-of-window addresses never hit.
    assign wr_th   = wr && (addr == ADDR_TH);
    assign wr_tl   = wr && (addr == ADDR_TL);
    assign wr_tcon = wr && (addr == ADDR_TCON);
    assign wr_led  = wr && (addr == ADDR_LED);
    assign wr_digi = wr && (addr == ADDR_DIGI);

    assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF);
    assign irq_set  = overflow && tcon[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th       <= '0;
            tl       <= '0;
            tcon     <= '0;
            led_reg  <= '0;
            digi_reg <= '0;
            systick  <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            systick <= systick + 32'd1;
            sw_meta <= switch;
            sw_sync <= sw_meta;

            // Reload reads the pre-edge TH, so a same-cycle TH write only
            // affects the following reload.
            if (wr_th) begin
                th <= wdata;
            end

            // A CPU write to TL overrides counting in that cycle.
            if (wr_tl) begin
                tl <= wdata;
            end else if (tcon[0]) begin
                if (tl == 32'hFFFF_FFFF) begin
                    tl <= th;
                end else begin
                    tl <= tl + 32'd1;
                end
            end

            // Overflow-set is ORed into a software write so an ISR clearing
            // the status bit on the overflow edge cannot lose an interrupt.
            if (wr_tcon) begin
                tcon[1:0] <= wdata[1:0];
                tcon[2]   <= wdata[2] | irq_set;
            end else if (irq_set) begin
                tcon[2] <= 1'b1;
            end

            if (wr_led) begin
                led_reg <= wdata[7:0];
            end
            if (wr_digi) begin
                digi_reg <= wdata[11:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                ADDR_TH:      rdata = th;
                ADDR_TL:      rdata = tl;
                ADDR_TCON:    rdata = {29'd0, tcon};
                ADDR_LED:     rdata = {24'd0, led_reg};
                ADDR_SWITCH:  rdata = {24'd0, sw_sync};
                ADDR_DIGI:    rdata = {20'd0, digi_reg};
                ADDR_SYSTICK: rdata = systick;
                default:      rdata = '0;
            endcase
        end
    end

    assign led    = led_reg;
    assign digi   = digi_reg;
    assign irqout = tcon[1] & tcon[2];

endmodule

// File: tb/tb_peripheral_timer.sv
`timescale 1ns/1ps
// Directed bench for peripheral_timer. Inputs change just after the falling
// edge; outputs are sampled a nanosecond later, well away from the rising edge.

module tb_peripheral_timer;

    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LED     = 32'h4000_000C;
    localparam logic [31:0] A_SWITCH  = 32'h4000_0010;
    localparam logic [31:0] A_DIGI    = 32'h4000_0014;
    localparam logic [31:0] A_SYSTICK = 32'h4000_0018;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [7:0]  switch;
    logic [11:0] digi;
    logic        irqout;

    int errors = 0;
    int checks = 0;

    peripheral_timer dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .led    (led),
        .switch (switch),
        .digi   (digi),
        .irqout (irqout)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd   = 1'b1;
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        rd    = 1'b0;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        wr    = 1'b0;
        wdata = '0;
    endtask

    initial begin
        reset  = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        addr   = '0;
        wdata  = '0;
        switch = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_led", {24'd0, led}, 32'h0);
        check("rst_digi", {20'd0, digi}, 32'h0);
        check("rst_irq", {31'd0, irqout}, 32'h0);
        addr = A_TH;
        #1;
        check("rst_rdata_rd0", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd_chk("rst_th", A_TH, 32'h0);
        rd_chk("rst_tl", A_TL, 32'h0);
        rd_chk("rst_tcon", A_TCON, 32'h0);
        rd_chk("rst_led_rd", A_LED, 32'h0);
        rd_chk("rst_sw_rd", A_SWITCH, 32'h0);
        rd_chk("rst_digi_rd", A_DIGI, 32'h0);
        rd_chk("rst_systick0", A_SYSTICK, 32'h0);
        for (int i = 0; i < 5; i++) step();
        rd_chk("systick5", A_SYSTICK, 32'd5);

        // SYSTICK is read-only: one more edge passes during the write
        wr_reg(A_SYSTICK, 32'hDEAD_0000);
        rd_chk("systick_wr_ignored", A_SYSTICK, 32'd6);

        // Periodic interrupt
        wr_reg(A_TH, 32'hFFFF_FFFC);
        wr_reg(A_TL, 32'hFFFF_FFFC);
        rd_chk("tl_hold_disabled", A_TL, 32'hFFFF_FFFC);
        wr_reg(A_TCON, 32'h3);
        rd_chk("tl_start", A_TL, 32'hFFFF_FFFC);
        step(); rd_chk("tl_fd", A_TL, 32'hFFFF_FFFD);
        check("irq_fd", {31'd0, irqout}, 32'h0);
        step(); rd_chk("tl_fe", A_TL, 32'hFFFF_FFFE);
        step(); rd_chk("tl_ff", A_TL, 32'hFFFF_FFFF);
        check("irq_ff", {31'd0, irqout}, 32'h0);
        step(); rd_chk("tl_reload", A_TL, 32'hFFFF_FFFC);
        check("irq_reload", {31'd0, irqout}, 32'h1);
        rd_chk("tcon_after_ovf", A_TCON, 32'h7);

        // Interrupt clear while running (TL FC -> FD on this edge)
        wr_reg(A_TCON, 32'h3);
        check("irq_cleared", {31'd0, irqout}, 32'h0);
        rd_chk("tl_after_clr", A_TL, 32'hFFFF_FFFD);
        step(); check("irq_clr_fe", {31'd0, irqout}, 32'h0);
        step(); check("irq_clr_ff", {31'd0, irqout}, 32'h0);
        step(); check("irq_period4", {31'd0, irqout}, 32'h1);
        rd_chk("tl_reload2", A_TL, 32'hFFFF_FFFC);

        // Clear on the exact overflow edge: set must win
        step(); step(); step();
        rd_chk("tl_ff2", A_TL, 32'hFFFF_FFFF);
        wr_reg(A_TCON, 32'h3);
        rd_chk("tcon_simul", A_TCON, 32'h7);
        check("irq_simul", {31'd0, irqout}, 32'h1);

        // I/O registers
        wr_reg(A_LED, 32'h0000_01A5);
        check("led_out", {24'd0, led}, 32'hA5);
        rd_chk("led_rd", A_LED, 32'hA5);
        wr_reg(A_DIGI, 32'h0000_F3F6);
        check("digi_out", {20'd0, digi}, 32'h3F6);
        rd_chk("digi_rd", A_DIGI, 32'h3F6);
        switch = 8'h5C;
        step(); rd_chk("sw_1edge", A_SWITCH, 32'h0);
        step(); rd_chk("sw_2edge", A_SWITCH, 32'h5C);

        // Decode
        rd_chk("rd_misaligned", 32'h4000_0002, 32'h0);
        rd_chk("rd_unmapped", 32'h4000_001C, 32'h0);
        rd   = 1'b0;
        addr = A_TH;
        #1;
        check("rd0_mapped", rdata, 32'h0);
        wr_reg(32'h4000_0020, 32'h1234_5678);
        rd_chk("unmapped_wr_th", A_TH, 32'hFFFF_FFFC);
        check("unmapped_wr_led", {24'd0, led}, 32'hA5);
        check("unmapped_wr_digi", {20'd0, digi}, 32'h3F6);

        // Reset mid-count aborts everything
        reset = 1'b0;
        #1;
        check("midrst_irq", {31'd0, irqout}, 32'h0);
        rd_chk("midrst_tl", A_TL, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(); step();
        check("postrst_irq", {31'd0, irqout}, 32'h0);
        rd_chk("postrst_tcon", A_TCON, 32'h0);
        rd_chk("postrst_tl", A_TL, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
